fetch_unit: RTL and testbench

- Instruction-fetch stage of the 16-bit WISC-15 core.
- Owns the architectural PC and drives the instruction-memory request/ready handshake.
- Captures each returned instruction into the IF/ID pipeline register.
- Takes redirect targets from the next-PC logic, which sits directly downstream. `pc_out` feeds that logic's PC input; that logic's target output returns here as `redirect_pc`.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 14 +
 rtl/fetch_unit_skid.sv | 38 +++
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the WISC-15 instruction-fetch stage.
// Contents: fetch FSM state encoding, reset/NOP defaults and the
// {instr, pc} entry type carried by the skid buffer.
package fetch_unit_pkg;

    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready handshake.
//   req   : fetch request (fetch -> memory)
//   addr  : word address of the request (fetch -> memory)
//   rdy   : request completes this cycle when req & rdy (memory -> fetch)
//   rdata : instruction word, valid with rdy (memory -> fetch)
interface fetch_unit_if;
    logic        req;
    logic [15:0] addr;
    logic        rdy;
    logic [15:0] rdata;

    modport master (output req, output addr, input rdy, input rdata);
    modport slave  (input req, input addr, output rdy, output rdata);
endinterface

// File: rtl/fetch_unit_skid.sv
// One-entry {instr, pc} skid buffer for the fetch stage.
//   clk, rst_n : clock, async active-low reset
//   load       : capture in_entry and mark full
//   unload     : entry consumed, mark empty
//   clear      : flush (wins over load)
//   in_entry   : entry to capture
//   out_entry  : stored entry
//   full       : entry present
module fetch_skid_buf
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  fetch_entry_t in_entry,
    output fetch_entry_t out_entry,
    output logic         full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 1'b0;
            out_entry <= '0;
        end else begin
            if (clear || unload) begin
                full <= 1'b0;
            end else if (load) begin
                full <= 1'b1;
            end
            if (load && !clear) begin
                out_entry <= in_entry;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// WISC-15 instruction-fetch stage: owns the PC, drives the instruction
// memory handshake and fills the IF/ID pipeline register.
//   clk, rst_n      : clock, async active-low reset
//   redirect_valid  : load redirect_pc (taken branch/call/ret downstream)
//   redirect_pc     : target PC from the next-PC logic
//   stall           : decode cannot accept a new IF/ID entry
//   halt            : decode holds a HALT instruction
//   imem            : instruction-memory handshake (master side)
//   pc_out          : current fetch PC
//   if_id_instr     : instruction to decode (NOP_INSTR when not valid)
//   if_id_pc        : PC of if_id_instr
//   if_id_valid     : IF/ID entry valid
//   halted          : core halted, exit only via reset
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [15:0]         redirect_pc,
    input  logic                stall,
    input  logic                halt,
    fetch_unit_if.master        imem,
    output logic [15:0]         pc_out,
    output logic [15:0]         if_id_instr,
    output logic [15:0]         if_id_pc,
    output logic                if_id_valid,
    output logic                halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  drain_addr;   // address of the stale request being drained
    logic         req_q;
    logic         halt_pend;
    logic [15:0]  id_instr_q;
    logic [15:0]  id_pc_q;
    logic         id_valid_q;

    logic         fire;
    logic         active;
    logic         redir;
    logic         halt_go;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_clear;
    logic         skid_full;
    fetch_entry_t skid_in;
    fetch_entry_t skid_out;

    assign fire    = req_q & imem.rdy;
    assign active  = (state != ST_HALTED);
    assign redir   = redirect_valid & active;
    assign halt_go = halt & active & ~redirect_valid;

    always_comb begin
        skid_clear  = redir | halt_go;
        skid_load   = !skid_clear && (state == ST_FETCH) && fire && stall && id_valid_q;
        skid_unload = !skid_clear && (state == ST_HOLD) && !stall;
        skid_in     = '{instr: imem.rdata, pc: pc};
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .in_entry  (skid_in),
        .out_entry (skid_out),
        .full      (skid_full)
    );

    // req is registered from the next state, so it is low during reset and
    // first rises one edge after rst_n deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
            req_q      <= 1'b0;
            halt_pend  <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else if (redir) begin
            id_valid_q <= 1'b0;
            halt_pend  <= 1'b0;
            pc         <= redirect_pc;
            req_q      <= 1'b1;
            if (req_q && !imem.rdy) begin
                // The stale request must complete at its original address.
                state <= ST_DRAIN;
                if (state != ST_DRAIN) drain_addr <= pc;
            end else begin
                state <= ST_FETCH;
            end
        end else if (halt_go) begin
            id_valid_q <= 1'b0;
            if (req_q && !imem.rdy) begin
                halt_pend <= 1'b1;
                state     <= ST_DRAIN;
                req_q     <= 1'b1;
                if (state != ST_DRAIN) drain_addr <= pc;
            end else begin
                if (fire && (state == ST_FETCH || halt_pend)) pc <= pc + 16'd1;
                state     <= ST_HALTED;
                req_q     <= 1'b0;
                halt_pend <= 1'b0;
            end
        end else begin
            unique case (state)
                ST_FETCH: begin
                    req_q <= 1'b1;
                    if (fire) begin
                        pc <= pc + 16'd1;
                        if (!stall || !id_valid_q) begin
                            id_instr_q <= imem.rdata;
                            id_pc_q    <= pc;
                            id_valid_q <= 1'b1;
                        end else begin
                            state <= ST_HOLD;
                            req_q <= 1'b0;
                        end
                    end else if (!stall) begin
                        id_valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        id_instr_q <= skid_out.instr;
                        id_pc_q    <= skid_out.pc;
                        id_valid_q <= skid_full;
                        state      <= ST_FETCH;
                        req_q      <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (imem.rdy) begin
                        halt_pend <= 1'b0;
                        if (halt_pend) begin
                            pc    <= pc + 16'd1;
                            state <= ST_HALTED;
                            req_q <= 1'b0;
                        end else begin
                            state <= ST_FETCH;
                            req_q <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.req    = req_q;
    assign imem.addr   = (state == ST_DRAIN) ? drain_addr : pc;
    assign pc_out      = pc;
    assign if_id_instr = id_valid_q ? id_instr_q : NOP_INSTR;
    assign if_id_pc    = id_pc_q;
    assign if_id_valid = id_valid_q;
    assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed cycle table from reset
// through streaming, stall/HOLD, redirect drain, redirect-vs-halt, PC wrap
// and halt drain, followed by hand-written halt-freeze and async-reset
// sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        halt;
    logic [15:0] pc_out;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    int errors = 0;
    int checks = 0;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .halt           (halt),
        .imem           (imem),
        .pc_out         (pc_out),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [15:0] rpc;
        logic        st;
        logic        hl;
        logic        rdy;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_pc;
        logic        e_val;
        logic [15:0] e_instr;
        logic [15:0] e_idpc;
        logic        e_halt;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic rv, input logic [15:0] rpc, input logic st,
                                input logic hl, input logic rdy, input logic [15:0] rdata,
                                input logic e_req, input logic [15:0] e_addr,
                                input logic [15:0] e_pc, input logic e_val,
                                input logic [15:0] e_instr, input logic [15:0] e_idpc,
                                input logic e_halt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.st = st; v.hl = hl; v.rdy = rdy; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_val = e_val;
        v.e_instr = e_instr; v.e_idpc = e_idpc; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [15:0] e_addr,
                             input logic [15:0] e_pc, input logic e_val,
                             input logic [15:0] e_instr, input logic [15:0] e_idpc,
                             input logic e_halt);
        check1 ({tag, " req"},    imem.req,    e_req);
        check16({tag, " addr"},   imem.addr,   e_addr);
        check16({tag, " pc_out"}, pc_out,      e_pc);
        check1 ({tag, " valid"},  if_id_valid, e_val);
        check16({tag, " instr"},  if_id_instr, e_instr);
        check16({tag, " id_pc"},  if_id_pc,    e_idpc);
        check1 ({tag, " halted"}, halted,      e_halt);
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        stall          = 1'b0;
        halt           = 1'b0;
        imem.rdy       = 1'b0;
        imem.rdata     = 16'h0000;
    endtask

    initial begin
        //            rv  rpc      st hl rdy rdata     | req addr     pc       val instr    idpc     hlt
        tbl[0]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000,   0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[1]  = mk(0, 16'h0000, 0, 0, 1, 16'h1111,   1, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        tbl[2]  = mk(0, 16'h0000, 0, 0, 1, 16'h2222,   1, 16'h0001, 16'h0001, 1, 16'h1111, 16'h0000, 0);
        tbl[3]  = mk(0, 16'h0000, 0, 0, 1, 16'h3333,   1, 16'h0002, 16'h0002, 1, 16'h2222, 16'h0001, 0);
        tbl[4]  = mk(0, 16'h0000, 0, 0, 1, 16'h4444,   1, 16'h0003, 16'h0003, 1, 16'h3333, 16'h0002, 0);
        tbl[5]  = mk(0, 16'h0000, 0, 0, 1, 16'h5555,   1, 16'h0004, 16'h0004, 1, 16'h4444, 16'h0003, 0);
        // stall while ABCD returns at pc 5: goes to the skid buffer, HOLD
        tbl[6]  = mk(0, 16'h0000, 1, 0, 1, 16'hABCD,   1, 16'h0005, 16'h0005, 1, 16'h5555, 16'h0004, 0);
        tbl[7]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000,   0, 16'h0006, 16'h0006, 1, 16'h5555, 16'h0004, 0);
        tbl[8]  = mk(0, 16'h0000, 1, 0, 1, 16'hDEAD,   0, 16'h0006, 16'h0006, 1, 16'h5555, 16'h0004, 0);
        tbl[9]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000,   0, 16'h0006, 16'h0006, 1, 16'h5555, 16'h0004, 0);
        tbl[10] = mk(0, 16'h0000, 0, 0, 0, 16'h0000,   1, 16'h0006, 16'h0006, 1, 16'hABCD, 16'h0005, 0);
        tbl[11] = mk(0, 16'h0000, 0, 0, 1, 16'h6666,   1, 16'h0006, 16'h0006, 0, 16'h0000, 16'h0005, 0);
        tbl[12] = mk(0, 16'h0000, 0, 0, 0, 16'h0000,   1, 16'h0007, 16'h0007, 1, 16'h6666, 16'h0006, 0);
        // redirect to 0x40 while the request to 7 is pending; drain it
        tbl[13] = mk(1, 16'h0040, 0, 0, 0, 16'h0000,   1, 16'h0007, 16'h0007, 0, 16'h0000, 16'h0006, 0);
        tbl[14] = mk(0, 16'h0000, 0, 0, 0, 16'h0000,   1, 16'h0007, 16'h0040, 0, 16'h0000, 16'h0006, 0);
        tbl[15] = mk(0, 16'h0000, 0, 0, 0, 16'h0000,   1, 16'h0007, 16'h0040, 0, 16'h0000, 16'h0006, 0);
        tbl[16] = mk(0, 16'h0000, 0, 0, 1, 16'hBAD1,   1, 16'h0007, 16'h0040, 0, 16'h0000, 16'h0006, 0);
        tbl[17] = mk(0, 16'h0000, 0, 0, 1, 16'h4040,   1, 16'h0040, 16'h0040, 0, 16'h0000, 16'h0006, 0);
        // halt + redirect together: redirect wins
        tbl[18] = mk(1, 16'h0100, 0, 1, 1, 16'h4141,   1, 16'h0041, 16'h0041, 1, 16'h4040, 16'h0040, 0);
        tbl[19] = mk(0, 16'h0000, 0, 0, 1, 16'h0100,   1, 16'h0100, 16'h0100, 0, 16'h0000, 16'h0040, 0);
        // redirect to 0xFFFF, then wrap to 0x0000
        tbl[20] = mk(1, 16'hFFFF, 0, 0, 1, 16'h5A5A,   1, 16'h0101, 16'h0101, 1, 16'h0100, 16'h0100, 0);
        tbl[21] = mk(0, 16'h0000, 0, 0, 1, 16'hF00F,   1, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 16'h0100, 0);
        // halt with outstanding request: drain, then halted with pc + 1
        tbl[22] = mk(0, 16'h0000, 0, 1, 0, 16'h0000,   1, 16'h0000, 16'h0000, 1, 16'hF00F, 16'hFFFF, 0);
        tbl[23] = mk(0, 16'h0000, 0, 0, 1, 16'h1234,   1, 16'h0000, 16'h0000, 0, 16'h0000, 16'hFFFF, 0);
        tbl[24] = mk(1, 16'h0055, 1, 1, 1, 16'h7777,   0, 16'h0001, 16'h0001, 0, 16'h0000, 16'hFFFF, 1);

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            check_all($sformatf("step%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_pc,
                      tbl[i].e_val, tbl[i].e_instr, tbl[i].e_idpc, tbl[i].e_halt);
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            stall          = tbl[i].st;
            halt           = tbl[i].hl;
            imem.rdy       = tbl[i].rdy;
            imem.rdata     = tbl[i].rdata;
            @(negedge clk);
        end

        // Halted: every input ignored, pc frozen at 1 for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            stall          = i[0];
            redirect_valid = i[1];
            halt           = i[2];
            redirect_pc    = 16'(i * 16'h0111);
            imem.rdy       = 1'b1;
            imem.rdata     = 16'hC0DE;
            @(negedge clk);
            check1 ($sformatf("frz%0d req", i),    imem.req, 1'b0);
            check16($sformatf("frz%0d pc", i),     pc_out,   16'h0001);
            check1 ($sformatf("frz%0d halted", i), halted,   1'b1);
        end

        // Async reset out of HALTED, mid-cycle.
        idle_inputs();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all("rst_halted", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

        // Halt with no outstanding request (req still low after reset).
        @(negedge clk);
        rst_n = 1'b1;
        halt  = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check_all("halt_idle", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);

        // Reset asserted in the middle of a redirect drain.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_all("drain", 1'b1, 16'h0000, 16'h0200, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all("rst_drain", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst", 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
